// File: rtl/digit_scan.sv
// digit_scan: time-multiplexed driver for a 4-digit, common-anode 7-segment display.
// Each digit is lit for REFRESH_DIV clock cycles, cycling through digits 0,1,2,3.
// value, digit_en and dp are sampled only at the end of a full scan, so a change
// never shows up partway through a scan.
// All outputs come straight from flops, with no combinational path from any input.
// Optional feature: define DIGIT_SCAN_BLANK_EN to blank leading zero digits.
module digit_scan #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic [3:0]  digit_en,
  input  logic [3:0]  dp,
  output logic [3:0]  n,
  output logic [3:0]  an,
  output logic        dp_n,
  output logic        scan_tick
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt_r;
  logic [1:0]    idx_r;
  logic [15:0]   val_r;
  logic [3:0]    en_r;
  logic [3:0]    dp_r;
  logic [3:0]    n_r;
  logic [3:0]    an_r;
  logic          dp_n_r;
  logic          scan_tick_r;

  logic          wrap_s;
  logic          scan_wrap_s;
  logic [CW-1:0] cnt_nxt_s;
  logic [1:0]    idx_nxt_s;
  logic [15:0]   val_nxt_s;
  logic [3:0]    en_nxt_s;
  logic [3:0]    dp_nxt_s;
  logic          blank_s;
  logic          lit_s;
  logic [3:0]    n_nxt_s;
  logic [3:0]    an_nxt_s;
  logic          dp_n_nxt_s;

  // Returns nibble i of v; digit 0 is the least significant nibble.
  function automatic logic [3:0] nib(input logic [15:0] v, input logic [1:0] i);
    logic [3:0] r;
    case (i)
      2'd0:    r = v[3:0];
      2'd1:    r = v[7:4];
      2'd2:    r = v[11:8];
      2'd3:    r = v[15:12];
      default: r = v[3:0];
    endcase
    return r;
  endfunction

`ifdef DIGIT_SCAN_BLANK_EN
  // A digit is a leading zero when it and every more significant nibble are zero.
  // Digit 0 always shows, so a value of zero still displays a single 0.
  function automatic logic blanked(input logic [15:0] v, input logic [1:0] i);
    logic r;
    case (i)
      2'd0:    r = 1'b0;
      2'd1:    r = (v[15:4] == 12'h000);
      2'd2:    r = (v[15:8] == 8'h00);
      2'd3:    r = (v[15:12] == 4'h0);
      default: r = 1'b0;
    endcase
    return r;
  endfunction
`endif

  // Next-state logic: refresh counter, digit index, shadow loads and the next output values.
  always_comb begin
    wrap_s      = (cnt_r == CNT_MAX);
    scan_wrap_s = wrap_s && (idx_r == 2'd3);
    if (wrap_s) begin
      cnt_nxt_s = '0;
      idx_nxt_s = idx_r + 2'd1;
    end else begin
      cnt_nxt_s = cnt_r + CW'(1);
      idx_nxt_s = idx_r;
    end
    if (scan_wrap_s) begin
      val_nxt_s = value;
      en_nxt_s  = digit_en;
      dp_nxt_s  = dp;
    end else begin
      val_nxt_s = val_r;
      en_nxt_s  = en_r;
      dp_nxt_s  = dp_r;
    end
`ifdef DIGIT_SCAN_BLANK_EN
    blank_s = blanked(val_nxt_s, idx_nxt_s);
`else
    blank_s = 1'b0;
`endif
    lit_s   = en_nxt_s[idx_nxt_s] && !blank_s;
    n_nxt_s = nib(val_nxt_s, idx_nxt_s);
    if (lit_s) begin
      an_nxt_s   = ~(4'b0001 << idx_nxt_s);
      dp_n_nxt_s = ~dp_nxt_s[idx_nxt_s];
    end else begin
      an_nxt_s   = 4'b1111;
      dp_n_nxt_s = 1'b1;
    end
  end

  // State and output registers; reset takes priority and leaves the display dark.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r       <= '0;
      idx_r       <= 2'd0;
      val_r       <= 16'h0000;
      en_r        <= 4'h0;
      dp_r        <= 4'h0;
      n_r         <= 4'h0;
      an_r        <= 4'b1111;
      dp_n_r      <= 1'b1;
      scan_tick_r <= 1'b0;
    end else begin
      cnt_r       <= cnt_nxt_s;
      idx_r       <= idx_nxt_s;
      val_r       <= val_nxt_s;
      en_r        <= en_nxt_s;
      dp_r        <= dp_nxt_s;
      n_r         <= n_nxt_s;
      an_r        <= an_nxt_s;
      dp_n_r      <= dp_n_nxt_s;
      scan_tick_r <= scan_wrap_s;
    end
  end

  assign n         = n_r;
  assign an        = an_r;
  assign dp_n      = dp_n_r;
  assign scan_tick = scan_tick_r;

endmodule

// File: tb/tb_digit_scan.sv
// tb_digit_scan: directed bench for digit_scan.
// u4 runs with REFRESH_DIV=4 and covers the scan order, tear-free input capture and
// mid-scan reset. u1 runs with REFRESH_DIV=1 and covers digit enables, decimal points
// and leading-zero handling; the expected results follow DIGIT_SCAN_BLANK_EN.
module tb_digit_scan;

`ifdef DIGIT_SCAN_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset4, reset1;
  logic [15:0] value4, value1;
  logic [3:0]  en4, en1, dp4, dp1;
  logic [3:0]  n4, an4, n1, an1;
  logic        dpn4, tick4, dpn1, tick1;
  int          checks = 0;
  int          errors = 0;

  digit_scan #(.REFRESH_DIV(4)) u4 (
    .clk(clk), .reset(reset4), .value(value4), .digit_en(en4), .dp(dp4),
    .n(n4), .an(an4), .dp_n(dpn4), .scan_tick(tick4)
  );

  digit_scan #(.REFRESH_DIV(1)) u1 (
    .clk(clk), .reset(reset1), .value(value1), .digit_en(en1), .dp(dp1),
    .n(n1), .an(an1), .dp_n(dpn1), .scan_tick(tick1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance cyc cycles on u4 and check every cycle; scan_tick is expected only on the first.
  task automatic expect4(input int cyc, input string tag, input logic [3:0] ean,
                         input logic [3:0] en_, input logic edpn, input logic etick);
    for (int c = 0; c < cyc; c++) begin
      tick();
      chk({tag, "/an"}, an4, ean);
      chk({tag, "/n"}, n4, en_);
      chk({tag, "/dp_n"}, {3'b000, dpn4}, {3'b000, edpn});
      chk({tag, "/tick"}, {3'b000, tick4}, {3'b000, (c == 0) ? etick : 1'b0});
    end
  endtask

  // Advance one cycle on u1 and check it.
  task automatic expect1(input string tag, input logic [3:0] ean, input logic [3:0] en_,
                         input logic edpn, input logic etick);
    tick();
    chk({tag, "/an"}, an1, ean);
    chk({tag, "/n"}, n1, en_);
    chk({tag, "/dp_n"}, {3'b000, dpn1}, {3'b000, edpn});
    chk({tag, "/tick"}, {3'b000, tick1}, {3'b000, etick});
  endtask

  initial begin
    reset4 = 1'b1; value4 = 16'h1234; en4 = 4'hF; dp4 = 4'h0;
    reset1 = 1'b1; value1 = 16'h1234; en1 = 4'b0101; dp1 = 4'b0001;
    tick();
    tick();
    chk("rst4/an", an4, 4'b1111);
    chk("rst4/n", n4, 4'h0);
    chk("rst4/dp_n", {3'b000, dpn4}, 4'h1);
    chk("rst4/tick", {3'b000, tick4}, 4'h0);
    chk("rst1/an", an1, 4'b1111);

    // u4: display stays dark until the first shadow load, then shows 4,3,2,1.
    reset4 = 1'b0;
    expect4(15, "boot", 4'b1111, 4'h0, 1'b1, 1'b0);
    expect4(4, "s1d0", 4'b1110, 4'h4, 1'b1, 1'b1);
    expect4(4, "s1d1", 4'b1101, 4'h3, 1'b1, 1'b0);
    expect4(4, "s1d2", 4'b1011, 4'h2, 1'b1, 1'b0);
    expect4(4, "s1d3", 4'b0111, 4'h1, 1'b1, 1'b0);
    // Change value while digit 1 is lit: the rest of this scan keeps the old digits.
    expect4(4, "s2d0", 4'b1110, 4'h4, 1'b1, 1'b1);
    expect4(1, "s2d1", 4'b1101, 4'h3, 1'b1, 1'b0);
    value4 = 16'hABCD;
    expect4(3, "s2d1b", 4'b1101, 4'h3, 1'b1, 1'b0);
    expect4(4, "s2d2", 4'b1011, 4'h2, 1'b1, 1'b0);
    expect4(4, "s2d3", 4'b0111, 4'h1, 1'b1, 1'b0);
    expect4(4, "s3d0", 4'b1110, 4'hD, 1'b1, 1'b1);
    expect4(4, "s3d1", 4'b1101, 4'hC, 1'b1, 1'b0);
    expect4(4, "s3d2", 4'b1011, 4'hB, 1'b1, 1'b0);
    expect4(4, "s3d3", 4'b0111, 4'hA, 1'b1, 1'b0);
    // One-cycle reset partway through digit 2.
    expect4(4, "s4d0", 4'b1110, 4'hD, 1'b1, 1'b1);
    expect4(4, "s4d1", 4'b1101, 4'hC, 1'b1, 1'b0);
    expect4(2, "s4d2", 4'b1011, 4'hB, 1'b1, 1'b0);
    reset4 = 1'b1;
    tick();
    chk("midrst/an", an4, 4'b1111);
    chk("midrst/n", n4, 4'h0);
    chk("midrst/dp_n", {3'b000, dpn4}, 4'h1);
    chk("midrst/tick", {3'b000, tick4}, 4'h0);
    reset4 = 1'b0;
    expect4(15, "rdark", 4'b1111, 4'h0, 1'b1, 1'b0);
    expect4(4, "rd0", 4'b1110, 4'hD, 1'b1, 1'b1);

    // u1: digit enables 0101 and a decimal point on digit 0 only.
    reset1 = 1'b0;
    expect1("u1dk1", 4'b1111, 4'h0, 1'b1, 1'b0);
    expect1("u1dk2", 4'b1111, 4'h0, 1'b1, 1'b0);
    expect1("u1dk3", 4'b1111, 4'h0, 1'b1, 1'b0);
    for (int s = 0; s < 2; s++) begin
      expect1("u1d0", 4'b1110, 4'h4, 1'b0, 1'b1);
      expect1("u1d1", 4'b1111, 4'h3, 1'b1, 1'b0);
      expect1("u1d2", 4'b1011, 4'h2, 1'b1, 1'b0);
      expect1("u1d3", 4'b1111, 4'h1, 1'b1, 1'b0);
    end

    // u1 leading-zero handling; u1 is now at idx 3, so the next edge loads the inputs.
    value1 = 16'h0005; en1 = 4'hF; dp1 = 4'hF;
    expect1("z5d0", 4'b1110, 4'h5, 1'b0, 1'b1);
    expect1("z5d1", BLANK ? 4'b1111 : 4'b1101, 4'h0, BLANK ? 1'b1 : 1'b0, 1'b0);
    expect1("z5d2", BLANK ? 4'b1111 : 4'b1011, 4'h0, BLANK ? 1'b1 : 1'b0, 1'b0);
    value1 = 16'h0000;
    expect1("z5d3", BLANK ? 4'b1111 : 4'b0111, 4'h0, BLANK ? 1'b1 : 1'b0, 1'b0);
    expect1("z0d0", 4'b1110, 4'h0, 1'b0, 1'b1);
    expect1("z0d1", BLANK ? 4'b1111 : 4'b1101, 4'h0, BLANK ? 1'b1 : 1'b0, 1'b0);
    expect1("z0d2", BLANK ? 4'b1111 : 4'b1011, 4'h0, BLANK ? 1'b1 : 1'b0, 1'b0);
    value1 = 16'h0105;
    expect1("z0d3", BLANK ? 4'b1111 : 4'b0111, 4'h0, BLANK ? 1'b1 : 1'b0, 1'b0);
    expect1("zmd0", 4'b1110, 4'h5, 1'b0, 1'b1);
    expect1("zmd1", 4'b1101, 4'h0, 1'b0, 1'b0);
    expect1("zmd2", 4'b1011, 4'h1, 1'b0, 1'b0);
    expect1("zmd3", BLANK ? 4'b1111 : 4'b0111, 4'h0, BLANK ? 1'b1 : 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/digit_scan.md
DIGIT_SCAN -- requirements
Module: digit_scan

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, clock cycles each digit is lit; legal range 1..2^20.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port value  input  16  four hex nibbles; digit i = value[4i+3:4i], digit 0 least significant.
REQ-005 SHALL have port digit_en  input  4  per-digit enable; 0 forces that digit dark.
REQ-006 SHALL have port dp  input  4  per-digit decimal point request, active-high.
REQ-007 SHALL have port n  output  4  nibble for the currently lit digit, fed to the downstream hex-to-segment decoder.
REQ-008 SHALL have port an  output  4  digit anodes, active-low; at most one bit low.
REQ-009 SHALL have port dp_n  output  4-to-1 result, 1 bit  decimal point, active-low.
REQ-010 SHALL have port scan_tick  output  1  one-cycle pulse marking the start of a new 4-digit scan.

Function
REQ-011 SHALL keep refresh counter cnt, counting 0..REFRESH_DIV-1 and wrapping to 0; width is clog2(REFRESH_DIV), minimum 1 bit.
REQ-012 SHALL keep 2-bit digit index idx, advancing 0->1->2->3->0 on each cycle where cnt == REFRESH_DIV-1; otherwise held.
REQ-013 SHALL, with REFRESH_DIV = 1, advance idx every cycle.
REQ-014 SHALL capture value, digit_en and dp into shadow registers on each cycle where cnt == REFRESH_DIV-1 and idx == 3 (scan wrap); otherwise shadows held, so input changes never tear a scan.
REQ-015 SHALL assert scan_tick high for exactly the cycle after each shadow load, i.e. the first cycle with idx == 0.
REQ-016 SHALL drive n = shadow nibble[idx], purely from registers; no combinational path from any input to any output.
REQ-017 SHALL drive an[i] = 0 only when i == idx and shadow digit_en[i] == 1 and digit i not blanked (REQ-026); all other bits 1.
REQ-018 SHALL drive dp_n = ~shadow dp[idx] when digit idx is lit, else 1.
REQ-019 SHALL change n, an, dp_n only on idx transitions or shadow loads; outputs stable for REFRESH_DIV cycles per digit.
REQ-020 SHALL give each digit equal on-time; one full scan = 4*REFRESH_DIV cycles.

Reset
REQ-021 SHALL, while reset is high at a clock edge, set cnt = 0, idx = 0, all shadow registers = 0, scan_tick = 0.
REQ-022 SHALL therefore show an = 4'b1111, dp_n = 1, n = 4'h0 from the cycle after reset through the first scan (display dark).
REQ-023 SHALL give reset priority over counting and shadow load; reset asserted mid-digit or mid-scan aborts immediately with no shadow load.
REQ-024 SHALL perform the first shadow load 4*REFRESH_DIV-1 cycles after reset deasserts.

Configuration
REQ-025 SHALL use macro DIGIT_SCAN_BLANK_EN to compile leading-zero blanking in or out.
REQ-026 SHALL, with DIGIT_SCAN_BLANK_EN defined, treat digit i (i >= 1) as blanked when shadow nibbles i..3 are all zero; digit 0 never blanked; blanked digits keep an[i] and dp_n high even if dp requested.
REQ-027 SHALL, without DIGIT_SCAN_BLANK_EN, never blank; every enabled digit lights including leading zeros.

Verification
REQ-028 SHALL verify, REFRESH_DIV=4: reset, value=16'h1234, digit_en=4'hF -> an 1111 for 15 cycles, then scan_tick pulse, an=1110 n=4 for 4 cycles, 1101 n=3, 1011 n=2, 0111 n=1, repeat.
REQ-029 SHALL verify, REFRESH_DIV=4: value changed 16'h1234->16'hABCD mid-scan at idx=1 -> remaining digits of scan still show 3,2,1; next scan shows D,C,B,A.
REQ-030 SHALL verify, REFRESH_DIV=1: digit_en=4'b0101, dp=4'b0001 -> an cycles 1110,1111,1011,1111; dp_n=0 only with idx 0.
REQ-031 SHALL verify, BLANK_EN defined: value=16'h0005 -> only an=1110 lit with n=5; value=16'h0000 -> digit 0 shows 0; BLANK_EN undefined: value=16'h0005 -> all four digits lit showing 5,0,0,0.
REQ-032 SHALL verify reset asserted for 1 cycle at idx=2 -> next cycle idx=0, an=1111, scan_tick=0, next scan_tick 4*REFRESH_DIV cycles after reset deasserts.
